// File: rtl/axilite_rtl_pkg.sv
// Shared AXI-Lite response codes and channel state encodings for the register file.
package axilite_rtl_pkg;

  localparam int AXIL_RESP_WIDTH = 2;
  localparam logic [AXIL_RESP_WIDTH-1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [AXIL_RESP_WIDTH-1:0] AXIL_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_COMMIT, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

endpackage

// File: rtl/axilite_addr_decode.sv
// Byte address to register index, with a flag saying whether the index names a real register.
module axilite_addr_decode #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 16,
  localparam int OFFS = $clog2(DATA_WIDTH / 8),
  localparam int IDX_W = ADDR_WIDTH - OFFS
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]      index,
  output logic                  in_range
);

  // Byte-offset bits inside a register are intentionally ignored.
  logic unused_offset;

  assign index         = addr[ADDR_WIDTH-1:OFFS];
  assign unused_offset = ^addr[OFFS-1:0];
  assign in_range      = {1'b0, index} < (IDX_W + 1)'(NUM_REGS);

endmodule

// File: rtl/axilite_regfile.sv
// AXI-Lite slave register bank with byte strobes, bus read-only masking and a hardware update port.
module axilite_regfile
  import axilite_rtl_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  input  logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  output logic [AXIL_RESP_WIDTH-1:0]     s_bresp,
  output logic                           s_bvalid,
  input  logic                           s_bready,
  input  logic [ADDR_WIDTH-1:0]          s_araddr,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  output logic [DATA_WIDTH-1:0]          s_rdata,
  output logic [AXIL_RESP_WIDTH-1:0]     s_rresp,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS-1:0]            hw_we,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_d,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - OFFS;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic                       aw_held, w_held;
  logic [ADDR_WIDTH-1:0]      awaddr_q;
  logic [DATA_WIDTH-1:0]      wdata_q;
  logic [STRB_W-1:0]          wstrb_q;
  logic [AXIL_RESP_WIDTH-1:0] bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0]      rdata_q;
  logic [DATA_WIDTH-1:0]      regs [NUM_REGS];

  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             wr_in_range, rd_in_range;
  logic             wr_ro, wr_ok, commit;
  logic [DATA_WIDTH-1:0] rd_val;
  logic             aw_hs, w_hs, ar_hs;

  axilite_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)
  ) u_wr_decode (
    .addr(awaddr_q), .index(wr_idx), .in_range(wr_in_range)
  );

  axilite_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)
  ) u_rd_decode (
    .addr(s_araddr), .index(rd_idx), .in_range(rd_in_range)
  );

  // Readies come only from held-beat flags and state, never from the valids.
  assign s_awready = (wr_state == WR_IDLE) && !aw_held;
  assign s_wready  = (wr_state == WR_IDLE) && !w_held;
  assign s_bvalid  = (wr_state == WR_RESP);
  assign s_bresp   = bresp_q;
  assign s_arready = (rd_state == RD_IDLE);
  assign s_rvalid  = (rd_state == RD_RESP);
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;
  assign ar_hs = s_arvalid && s_arready;

  always_comb begin
    wr_ro  = 1'b0;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == IDX_W'(i)) wr_ro = RO_MASK[i];
      if (rd_idx == IDX_W'(i)) rd_val = regs[i];
    end
  end

  assign wr_ok  = wr_in_range && !wr_ro;
  assign commit = (wr_state == WR_COMMIT) && wr_ok;

  always_comb begin
    wr_pulse = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (commit && (wr_idx == IDX_W'(i))) wr_pulse[i] = 1'b1;
    end
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE:   if ((aw_held || aw_hs) && (w_held || w_hs)) wr_next = WR_COMMIT;
      WR_COMMIT: wr_next = WR_RESP;
      WR_RESP:   if (s_bready) wr_next = WR_IDLE;
      default:   wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state <= WR_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= AXIL_RESP_OKAY;
    end else begin
      wr_state <= wr_next;
      if (aw_hs) begin
        aw_held  <= 1'b1;
        awaddr_q <= s_awaddr;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= s_wdata;
        wstrb_q <= s_wstrb;
      end
      if (wr_state == WR_COMMIT) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bresp_q <= wr_ok ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
      end
    end
  end

  // Strobed bus bytes beat the hardware port; unstrobed bytes still take hw_d.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_pulse[i] && wstrb_q[b])
            regs[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
          else if (hw_we[i])
            regs[i][b*8 +: 8] <= hw_d[i*DATA_WIDTH + b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (s_arvalid) rd_next = RD_RESP;
      RD_RESP: if (s_rready) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      rdata_q  <= '0;
      rresp_q  <= AXIL_RESP_OKAY;
    end else begin
      rd_state <= rd_next;
      if (ar_hs) begin
        rdata_q <= rd_in_range ? rd_val : '0;
        rresp_q <= rd_in_range ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_q
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

endmodule
